// File: rtl/icache_requester.sv
// Direct-mapped instruction cache issuing block reads to the memory controller.
// Optional hit/miss counters are compiled in with ICACHE_STAT_EN.
module icache_requester #(
  parameter int BLOCK_WIDTH = 1,
  parameter int BLOCK_SIZE  = 1 << BLOCK_WIDTH,
  parameter int CACHE_WIDTH = 8,
  parameter int BLOCK_NUM   = 1 << CACHE_WIDTH,
  parameter int TAG_WIDTH   = 32 - CACHE_WIDTH - BLOCK_WIDTH - 2
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst,
  input  logic                    Sys_rdy,
  input  logic                    IFIC_en,
  input  logic [31:0]             IFIC_addr,
  input  logic                    RoB_clear,
  output logic                    ICIF_en,
  output logic [31:0]             ICIF_inst,
  output logic                    ICMC_en,
  output logic [31:0]             ICMC_addr,
  input  logic                    MCIC_en,
  input  logic [32*BLOCK_SIZE-1:0] MCIC_block
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]             ICstat_hit,
  output logic [31:0]             ICstat_miss
`endif
);

  localparam int OFF_W    = BLOCK_WIDTH + 2;
  localparam int BLK_BITS = 32 * BLOCK_SIZE;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                  state_q, state_d;
  logic [BLOCK_NUM-1:0]    valid_q;
  logic [TAG_WIDTH-1:0]    tag_mem  [BLOCK_NUM];
  logic [BLK_BITS-1:0]     data_mem [BLOCK_NUM];

  logic [BLOCK_WIDTH-1:0]  in_word, req_word_q, req_word_d;
  logic [CACHE_WIDTH-1:0]  in_idx,  req_idx_q,  req_idx_d;
  logic [TAG_WIDTH-1:0]    in_tag,  req_tag_q,  req_tag_d;
  logic                    drop_q, drop_d;
  logic                    icmc_en_q, icmc_en_d;
  logic                    icif_en_d;
  logic [31:0]             icif_inst_d, icmc_addr_d;
  logic                    hit, accept_hit, start_miss, refill;
  logic                    unused_addr_bits;

  assign in_word = IFIC_addr[OFF_W-1:2];
  assign in_idx  = IFIC_addr[CACHE_WIDTH+OFF_W-1:OFF_W];
  assign in_tag  = IFIC_addr[31:CACHE_WIDTH+OFF_W];
  assign unused_addr_bits = ^IFIC_addr[1:0];

  assign hit        = valid_q[in_idx] && (tag_mem[in_idx] == in_tag);
  assign accept_hit = (state_q == IDLE) && IFIC_en && !RoB_clear && hit;
  assign start_miss = (state_q == IDLE) && IFIC_en && !RoB_clear && !hit;
  assign refill     = (state_q == MISS) && MCIC_en;

  // Dropped in the MCIC_en cycle so the controller, already idle, sees no new read.
  assign ICMC_en = icmc_en_q && !(Sys_rdy && MCIC_en);

  // Byte k of a block sits at the top end of the bus; words are little-endian.
  function automatic logic [31:0] pick_word(input logic [BLK_BITS-1:0] blk,
                                            input logic [BLOCK_WIDTH-1:0] w);
    logic [31:0] inst;
    inst = '0;
    for (int b = 0; b < 4; b++)
      inst[8*b +: 8] = blk[BLK_BITS - 1 - 8*(4*int'(w) + b) -: 8];
    return inst;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) state_q <= IDLE;
    else if (Sys_rdy) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_miss) state_d = MISS;
      MISS: if (MCIC_en)    state_d = IDLE;
    endcase
  end

  // NOTE: every signal gets a default before the case, otherwise a missed
  // branch would infer a latch.
  always_comb begin
    icif_en_d   = 1'b0;
    icif_inst_d = ICIF_inst;
    icmc_en_d   = icmc_en_q;
    icmc_addr_d = ICMC_addr;
    drop_d      = drop_q;
    req_word_d  = req_word_q;
    req_idx_d   = req_idx_q;
    req_tag_d   = req_tag_q;
    unique case (state_q)
      IDLE: begin
        if (accept_hit) begin
          icif_en_d   = 1'b1;
          icif_inst_d = pick_word(data_mem[in_idx], in_word);
        end else if (start_miss) begin
          req_word_d  = in_word;
          req_idx_d   = in_idx;
          req_tag_d   = in_tag;
          icmc_addr_d = {IFIC_addr[31:OFF_W], {OFF_W{1'b0}}};
          icmc_en_d   = 1'b1;
        end
      end
      MISS: begin
        if (RoB_clear) drop_d = 1'b1;
        if (MCIC_en) begin
          icmc_en_d   = 1'b0;
          icif_inst_d = pick_word(MCIC_block, req_word_q);
          icif_en_d   = !(drop_q || RoB_clear);
          drop_d      = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      ICIF_en    <= 1'b0;
      ICIF_inst  <= '0;
      icmc_en_q  <= 1'b0;
      ICMC_addr  <= '0;
      drop_q     <= 1'b0;
      req_word_q <= '0;
      req_idx_q  <= '0;
      req_tag_q  <= '0;
      valid_q    <= '0;
    end else if (Sys_rdy) begin
      ICIF_en    <= icif_en_d;
      ICIF_inst  <= icif_inst_d;
      icmc_en_q  <= icmc_en_d;
      ICMC_addr  <= icmc_addr_d;
      drop_q     <= drop_d;
      req_word_q <= req_word_d;
      req_idx_q  <= req_idx_d;
      req_tag_q  <= req_tag_d;
      if (refill) valid_q[req_idx_q] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone make stale
  // contents unreachable.
  always_ff @(posedge Sys_clk) begin
    if (Sys_rdy && refill) begin
      tag_mem[req_idx_q]  <= req_tag_q;
      data_mem[req_idx_q] <= MCIC_block;
    end
  end

`ifdef ICACHE_STAT_EN
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      ICstat_hit  <= '0;
      ICstat_miss <= '0;
    end else if (Sys_rdy) begin
      if (accept_hit) ICstat_hit  <= ICstat_hit + 32'd1;
      if (start_miss) ICstat_miss <= ICstat_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_requester.sv
// Self-checking bench for icache_requester: directed table, corner sequences,
// and randomized fetches against an address-level cache model.
module tb_icache_requester;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst, Sys_rdy, IFIC_en, RoB_clear, MCIC_en;
  logic [31:0] IFIC_addr;
  logic [63:0] MCIC_block;
  logic        ICIF_en, ICMC_en;
  logic [31:0] ICIF_inst, ICMC_addr;
`ifdef ICACHE_STAT_EN
  logic [31:0] ICstat_hit, ICstat_miss;
`endif

  icache_requester dut (
    .Sys_clk    (Sys_clk),
    .Sys_rst    (Sys_rst),
    .Sys_rdy    (Sys_rdy),
    .IFIC_en    (IFIC_en),
    .IFIC_addr  (IFIC_addr),
    .RoB_clear  (RoB_clear),
    .ICIF_en    (ICIF_en),
    .ICIF_inst  (ICIF_inst),
    .ICMC_en    (ICMC_en),
    .ICMC_addr  (ICMC_addr),
    .MCIC_en    (MCIC_en),
    .MCIC_block (MCIC_block)
`ifdef ICACHE_STAT_EN
    ,
    .ICstat_hit (ICstat_hit),
    .ICstat_miss(ICstat_miss)
`endif
  );

  always #5 Sys_clk = ~Sys_clk;

  int checks = 0;
  int failures = 0;
  int n_hit = 0;
  int n_miss = 0;

  // Model: which block base address each of the 256 lines currently holds.
  bit          line_vld  [256];
  logic [31:0] line_base [256];

  typedef struct {
    logic [31:0] addr;
    bit          flush;
    int          delay;
    bit          exp_hit;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [63:0] build_block(input logic [31:0] base);
    logic [63:0] blk;
    logic [31:0] wd;
    blk = '0;
    for (int w = 0; w < 2; w++) begin
      wd = mem_word(base + 32'(4*w));
      for (int b = 0; b < 4; b++) blk[8*(8 - (4*w + b)) - 1 -: 8] = wd[8*b +: 8];
    end
    return blk;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int idx;
    idx = int'((a / 8) % 256);
    return line_vld[idx] && (line_base[idx] == (a / 8) * 8);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) line_vld[i] = 1'b0;
  endtask

  // Entered and left at posedge+1; outputs are sampled on the falling edge.
  task automatic fetch(input logic [31:0] addr, input bit exp_hit, input logic [31:0] exp_inst,
                       input bit flush, input int delay, input string nm);
    logic [31:0] base;
    int idx;
    base = (addr / 8) * 8;
    idx  = int'((addr / 8) % 256);
    IFIC_en = 1'b1; IFIC_addr = addr;
    @(posedge Sys_clk); #1 IFIC_en = 1'b0;
    @(negedge Sys_clk);
    if (exp_hit) begin
      n_hit++;
      check({nm, " hit ICIF_en"}, 32'(ICIF_en), 32'd1);
      check({nm, " hit ICIF_inst"}, ICIF_inst, exp_inst);
      check({nm, " hit ICMC_en"}, 32'(ICMC_en), 32'd0);
    end else begin
      n_miss++;
      check({nm, " miss ICIF_en"}, 32'(ICIF_en), 32'd0);
      check({nm, " miss ICMC_en"}, 32'(ICMC_en), 32'd1);
      check({nm, " miss ICMC_addr"}, ICMC_addr, base);
      for (int d = 0; d < delay; d++) begin
        @(posedge Sys_clk); #1 RoB_clear = flush && (d == 0);
        @(negedge Sys_clk);
        check({nm, " ICMC_en held"}, 32'(ICMC_en), 32'd1);
      end
      @(posedge Sys_clk); #1;
      RoB_clear  = flush && (delay == 0);
      MCIC_en    = 1'b1;
      MCIC_block = build_block(base);
      @(negedge Sys_clk);
      check({nm, " ICMC_en in MCIC_en cycle"}, 32'(ICMC_en), 32'd0);
      @(posedge Sys_clk); #1 MCIC_en = 1'b0; RoB_clear = 1'b0;
      @(negedge Sys_clk);
      check({nm, " refill ICIF_en"}, 32'(ICIF_en), 32'(!flush));
      if (!flush) check({nm, " refill ICIF_inst"}, ICIF_inst, exp_inst);
      line_vld[idx]  = 1'b1;
      line_base[idx] = base;
    end
    @(posedge Sys_clk); #1;
  endtask

  task automatic clear_req(input logic [31:0] addr, input string nm);
    IFIC_en = 1'b1; RoB_clear = 1'b1; IFIC_addr = addr;
    @(posedge Sys_clk); #1 IFIC_en = 1'b0; RoB_clear = 1'b0;
    @(negedge Sys_clk);
    check({nm, " clear ICIF_en"}, 32'(ICIF_en), 32'd0);
    check({nm, " clear ICMC_en"}, 32'(ICMC_en), 32'd0);
    @(posedge Sys_clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    bit h;
    Sys_rst = 1'b0; Sys_rdy = 1'b1; IFIC_en = 1'b0; IFIC_addr = '0;
    RoB_clear = 1'b0; MCIC_en = 1'b0; MCIC_block = '0;
    model_clear();
    repeat (3) @(posedge Sys_clk);
    @(negedge Sys_clk);
    check("reset ICIF_en", 32'(ICIF_en), 32'd0);
    check("reset ICIF_inst", ICIF_inst, 32'd0);
    check("reset ICMC_en", 32'(ICMC_en), 32'd0);
    check("reset ICMC_addr", ICMC_addr, 32'd0);
    @(posedge Sys_clk); #1 Sys_rst = 1'b1;

    // Cold miss with the literal controller block.
    IFIC_en = 1'b1; IFIC_addr = 32'h0;
    @(posedge Sys_clk); #1 IFIC_en = 1'b0;
    @(negedge Sys_clk);
    check("cold ICMC_en", 32'(ICMC_en), 32'd1);
    check("cold ICMC_addr", ICMC_addr, 32'h0);
    @(posedge Sys_clk); #1 MCIC_en = 1'b1; MCIC_block = 64'h1300_0000_9300_1000;
    @(negedge Sys_clk);
    check("cold ICMC_en in MCIC_en cycle", 32'(ICMC_en), 32'd0);
    @(posedge Sys_clk); #1 MCIC_en = 1'b0;
    @(negedge Sys_clk);
    check("cold ICIF_en", 32'(ICIF_en), 32'd1);
    check("cold ICIF_inst", ICIF_inst, 32'h0000_0013);
    @(posedge Sys_clk); #1;
    n_miss++;
    line_vld[0] = 1'b1; line_base[0] = 32'h0;

    tbl.push_back('{32'h0000_0004, 1'b0, 0, 1'b1, 32'h0010_0093});
    tbl.push_back('{32'h0000_0800, 1'b0, 1, 1'b0, mem_word(32'h800)});
    tbl.push_back('{32'h0000_0000, 1'b0, 2, 1'b0, 32'h0000_0013});
    tbl.push_back('{32'h0000_0010, 1'b1, 2, 1'b0, 32'h0});
    tbl.push_back('{32'h0000_0014, 1'b0, 0, 1'b1, mem_word(32'h14)});
    tbl.push_back('{32'h0000_0010, 1'b0, 0, 1'b1, mem_word(32'h10)});
    tbl.push_back('{32'h0000_0804, 1'b0, 0, 1'b0, mem_word(32'h804)});
    tbl.push_back('{32'h0000_07F8, 1'b1, 0, 1'b0, 32'h0});
    tbl.push_back('{32'h0000_07FC, 1'b0, 3, 1'b1, mem_word(32'h7FC)});
    tbl.push_back('{32'h0000_0004, 1'b0, 1, 1'b0, 32'h0010_0093});
    foreach (tbl[i])
      fetch(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_inst, tbl[i].flush, tbl[i].delay,
            $sformatf("vec%0d@%h", i, tbl[i].addr));

    clear_req(32'h0000_1000, "clr-miss-addr");
    clear_req(32'h0000_0004, "clr-hit-addr");

    // Freeze right after a hit response: ICIF_en must hold while Sys_rdy=0.
    IFIC_en = 1'b1; IFIC_addr = 32'h4;
    @(posedge Sys_clk); #1 IFIC_en = 1'b0; Sys_rdy = 1'b0;
    @(negedge Sys_clk);
    check("freeze ICIF_en", 32'(ICIF_en), 32'd1);
    @(posedge Sys_clk); #1;
    @(negedge Sys_clk);
    check("freeze ICIF_en held", 32'(ICIF_en), 32'd1);
    check("freeze ICIF_inst held", ICIF_inst, 32'h0010_0093);
    @(posedge Sys_clk); #1 Sys_rdy = 1'b1;
    @(posedge Sys_clk); #1;
    @(negedge Sys_clk);
    check("unfreeze ICIF_en", 32'(ICIF_en), 32'd0);
    @(posedge Sys_clk); #1;
    n_hit++;

    // Reset while a miss is outstanding.
    IFIC_en = 1'b1; IFIC_addr = 32'h0000_0020;
    @(posedge Sys_clk); #1 IFIC_en = 1'b0;
    @(negedge Sys_clk);
    check("rst-miss ICMC_en before", 32'(ICMC_en), 32'd1);
    @(posedge Sys_clk); #1 Sys_rst = 1'b0;
    @(posedge Sys_clk); #1 Sys_rst = 1'b1;
    @(negedge Sys_clk);
    check("rst-miss ICMC_en", 32'(ICMC_en), 32'd0);
    check("rst-miss ICMC_addr", ICMC_addr, 32'd0);
    check("rst-miss ICIF_en", 32'(ICIF_en), 32'd0);
    @(posedge Sys_clk); #1;
    model_clear();
    n_hit = 0; n_miss = 0;
    fetch(32'h0000_0004, 1'b0, 32'h0010_0093, 1'b0, 1, "post-reset 0x4");

    for (int i = 0; i < 150; i++) begin
      a = (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 7)) << 3)
        | (32'($urandom_range(0, 1)) << 2);
      if ($urandom_range(0, 9) == 0) begin
        clear_req(a, $sformatf("rnd%0d@%h", i, a));
      end else begin
        h = model_hit(a);
        fetch(a, h, mem_word(a), !h && ($urandom_range(0, 4) == 0),
              int'($urandom_range(0, 3)), $sformatf("rnd%0d@%h", i, a));
      end
    end

`ifdef ICACHE_STAT_EN
    check("stat hit", ICstat_hit, 32'(n_hit));
    check("stat miss", ICstat_miss, 32'(n_miss));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_requester.md
Name: icache_requester

Overview:
- Direct-mapped instruction cache between the instruction-fetch unit (IF) and the memory controller's ICache port.
- Serves IF fetches from on-chip storage. On a miss, it initiates a block read on the ICMC_*/MCIC_* handshake, refills the line, then returns the requested 32-bit instruction.
- It is the requester end of the memory controller's ICache responder interface.

Parameters:
BLOCK_WIDTH, 1, log2 instructions per block (block = 4*2^BLOCK_WIDTH bytes)
BLOCK_SIZE, 1<<BLOCK_WIDTH, instructions per block
CACHE_WIDTH, 8, log2 number of lines
BLOCK_NUM, 1<<CACHE_WIDTH, number of lines
TAG_WIDTH, 32-CACHE_WIDTH-BLOCK_WIDTH-2, tag bits (21 at defaults)

Ports:
Sys_clk  in  1  clock, all state on rising edge
Sys_rst  in  1  synchronous active-low reset; reset when 0 at posedge
Sys_rdy  in  1  global enable; when 0 all state and outputs hold
IFIC_en  in  1  one-cycle fetch request pulse
IFIC_addr  in  32  fetch PC, word aligned
RoB_clear  in  1  pipeline flush (mispredict)
ICIF_en  out  1  one-cycle response valid
ICIF_inst  out  32  instruction
ICMC_en  out  1  block read request to memory controller
ICMC_addr  out  32  block-aligned address (low BLOCK_WIDTH+2 bits zero)
MCIC_en  in  1  one-cycle refill done pulse
MCIC_block  in  32*BLOCK_SIZE  refill data

Behaviour:
- Address split: word = addr[BLOCK_WIDTH+1:2]; index = addr[CACHE_WIDTH+BLOCK_WIDTH+1:BLOCK_WIDTH+2]; tag = addr[31:CACHE_WIDTH+BLOCK_WIDTH+2]. At defaults: word = addr[2], index = addr[10:3], tag = addr[31:11].
- Storage: per line a valid bit, a tag, and a 32*BLOCK_SIZE data field. Storage may be arrays or registers.
- Block byte order (fixed by controller):
  - Byte at address base+k sits at MCIC_block[8*(4*BLOCK_SIZE-k)-1 -: 8].
  - Instruction i = {byte 4i+3, byte 4i+2, byte 4i+1, byte 4i}, little-endian.
  - Data is stored as received; reordering happens on the read-out path.
- Reset (Sys_rst=0): state IDLE; all valid bits 0; drop=0; ICIF_en=0; ICIF_inst=0; ICMC_en=0; ICMC_addr=0.
- States: IDLE, MISS.
- IDLE:
  - RoB_clear=1: ICIF_en<=0 and any same-cycle IFIC_en is ignored (clear wins).
  - IFIC_en=1 and hit (valid[index] && tag match): ICIF_en<=1 and ICIF_inst<=selected word. Latency is 1 cycle. The cache remains in IDLE and can accept a new request the following cycle.
  - IFIC_en=1 and miss: latch the request address, ICMC_addr<=block-aligned address, ICMC_en<=1, ICIF_en<=0, go to MISS.
  - Otherwise: ICIF_en<=0.
- MISS:
  - ICMC_en and ICMC_addr hold until MCIC_en.
  - ICMC_en output = registered request AND NOT MCIC_en. It must be low in the MCIC_en cycle so the controller, already back in IDLE, does not restart the read.
  - IFIC_en is ignored.
  - RoB_clear=1: drop<=1.
  - On MCIC_en: write block, tag, and valid=1 to the latched index. Clear the ICMC_en register. ICIF_inst<=requested word taken from MCIC_block (not from storage). ICIF_en<=!(drop||RoB_clear). drop<=0. Go to IDLE.
- The refill always completes and is written even when flushed, because the controller cannot abort a transfer.
- IF contract: at most one outstanding request. IF issues the next request only after ICIF_en, or after RoB_clear.
- Sys_rdy=0 freezes state, storage and outputs. ICMC_en keeps its registered value.
- Reset mid-MISS: immediate return to IDLE, ICMC_en=0, all lines invalid. The controller is reset by the same reset.

Optional Feature:
- Macro: ICACHE_STAT_EN.
- Defined:
  - Adds outputs ICstat_hit[31:0] and ICstat_miss[31:0], reset to 0.
  - hit increments on each accepted hit; miss increments on each IDLE->MISS transition.
  - Both counters wrap at 2^32 and are frozen by Sys_rdy=0.
- Undefined: no counters and no extra ports; behaviour otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: reset, IFIC_en with addr 0x0000_0000.
  - Expect: next cycle ICMC_en=1, ICMC_addr=0x0.
  - Drive MCIC_en with block bytes 13,00,00,00,93,00,10,00 for addresses 0..7 (MCIC_block=64'h1300_0000_9300_1000).
  - Expect: ICIF_en=1 with ICIF_inst=0x0000_0013 one cycle after MCIC_en, and ICMC_en=0 in the MCIC_en cycle.
- Hit: IFIC_en addr 0x0000_0004 -> ICIF_en=1 next cycle, ICIF_inst=0x0010_0093, ICMC_en stays 0.
- Conflict: IFIC_en 0x0000_0800 (index 0, tag 1) -> miss with ICMC_addr=0x800, refill, response. Then re-request 0x0000_0000 -> miss again.
- Flush during miss:
  - Stimulus: miss on 0x10, pulse RoB_clear before MCIC_en.
  - Expect: ICIF_en stays 0; line is filled; re-request 0x14 -> hit in 1 cycle.
- Clear vs request: IFIC_en and RoB_clear in the same IDLE cycle -> no response, no ICMC_en.
- Reset mid-miss: Sys_rst=0 while in MISS -> ICMC_en=0 next cycle; a subsequent request to a previously filled address misses.
